// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES round-key store sequencer.
// Optional feature macro: KEY_ZEROIZE_EN (adds the ZERO state).
package aes_ctrl_pkg;

  localparam int MAX_ROUNDS = 14;
  localparam int ROUND_W    = 4;

  localparam logic [ROUND_W-1:0] NR_128 = ROUND_W'(10);
  localparam logic [ROUND_W-1:0] NR_192 = ROUND_W'(12);
  localparam logic [ROUND_W-1:0] NR_256 = ROUND_W'(14);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_READY,
    ST_CIPHER
`ifdef KEY_ZEROIZE_EN
    , ST_ZERO
`endif
  } state_t;

  typedef enum logic [1:0] {
    KS_128  = 2'd0,
    KS_192  = 2'd1,
    KS_256  = 2'd2,
    KS_RSVD = 2'd3
  } key_size_t;

  // Round count Nr for a key size; the reserved code behaves as AES-128.
  function automatic logic [ROUND_W-1:0] nr_of(key_size_t ks);
    case (ks)
      KS_192:  return NR_192;
      KS_256:  return NR_256;
      default: return NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Bus between the key-schedule sequencer, the key expander, key memory and datapath.
// Optional feature macro: KEY_ZEROIZE_EN (adds zeroize / key_zero_sel).
//
// Handshakes: key_load and op_start are single-cycle pulses sampled on the rising
// edge; exp_valid qualifies one expanded key in the cycle it is high and is only
// consumed while exp_req is high; round_adv consumes the key at readRound in that
// cycle; op_done is a one-cycle completion pulse. No input is ever queued.
interface aes_key_sched_ctrl_if;
  import aes_ctrl_pkg::*;

  logic               key_load;
  logic [1:0]         key_size;
  logic               exp_valid;
  logic               op_start;
  logic               round_adv;
  logic               exp_req;
  logic               dec_key_gen;
  logic [ROUND_W-1:0] writeRound;
  logic [ROUND_W-1:0] readRound;
  logic [ROUND_W-1:0] roundAmount;
  logic               key_ready;
  logic               busy;
  logic               op_done;
  state_t             dbg_state;
`ifdef KEY_ZEROIZE_EN
  logic               zeroize;
  logic               key_zero_sel;

  modport master (
    output key_load, key_size, exp_valid, op_start, round_adv, zeroize,
    input  exp_req, dec_key_gen, writeRound, readRound, roundAmount,
           key_ready, busy, op_done, dbg_state, key_zero_sel
  );
  modport slave (
    input  key_load, key_size, exp_valid, op_start, round_adv, zeroize,
    output exp_req, dec_key_gen, writeRound, readRound, roundAmount,
           key_ready, busy, op_done, dbg_state, key_zero_sel
  );
`else
  modport master (
    output key_load, key_size, exp_valid, op_start, round_adv,
    input  exp_req, dec_key_gen, writeRound, readRound, roundAmount,
           key_ready, busy, op_done, dbg_state
  );
  modport slave (
    input  key_load, key_size, exp_valid, op_start, round_adv,
    output exp_req, dec_key_gen, writeRound, readRound, roundAmount,
           key_ready, busy, op_done, dbg_state
  );
`endif
endinterface

// File: rtl/aes_round_ctr.sv
// Round index counter: synchronous clear, enable, saturates at a run-time limit.
module aes_round_ctr
  import aes_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [ROUND_W-1:0] limit_i,
  output logic [ROUND_W-1:0] cnt_o,
  output logic               at_lim_o
);
  logic [ROUND_W-1:0] cnt_q, cnt_d;

  assign cnt_o    = cnt_q;
  assign at_lim_o = (cnt_q >= limit_i);

  // Clear beats enable; never step past the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                 cnt_d = '0;
    else if (en_i && !at_lim_o) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES round-key store sequencer: drives key expansion into the round-key memory,
// then hands out read round indices for each cipher operation.
// Optional feature macro: KEY_ZEROIZE_EN (memory wipe through the ZERO state).
module aes_key_sched_ctrl
  import aes_ctrl_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  aes_key_sched_ctrl_if.slave  bus
);
  state_t             state_q, state_d;
  logic [ROUND_W-1:0] ra_q, ra_d;
  logic               op_done_q, op_done_d;
  logic               exp_req, key_ready, dec_key_gen, key_zero_sel;
  logic               wr_clr, wr_en, wr_at_lim, rd_clr, rd_en, rd_at_lim, ra_load;
  logic               load_ok;
  logic [ROUND_W-1:0] wr_cnt, rd_cnt, wr_lim;

`ifdef KEY_ZEROIZE_EN
  // key_load is not honoured while the wipe is running.
  assign load_ok = bus.key_load && (state_q != ST_ZERO);
  assign wr_lim  = (state_q == ST_ZERO) ? ROUND_W'(MAX_ROUNDS) : ra_q;
`else
  assign load_ok = bus.key_load;
  assign wr_lim  = ra_q;
`endif

  aes_round_ctr u_wr_ctr (
    .clk(clk), .reset(reset), .clr_i(wr_clr), .en_i(wr_en),
    .limit_i(wr_lim), .cnt_o(wr_cnt), .at_lim_o(wr_at_lim)
  );

  aes_round_ctr u_rd_ctr (
    .clk(clk), .reset(reset), .clr_i(rd_clr), .en_i(rd_en),
    .limit_i(ra_q), .cnt_o(rd_cnt), .at_lim_o(rd_at_lim)
  );

  // Next state, counter controls and outputs; zeroize > key_load > op_start.
  always_comb begin
    state_d      = state_q;
    exp_req      = 1'b0;
    key_ready    = 1'b0;
    dec_key_gen  = 1'b0;
    key_zero_sel = 1'b0;
    wr_clr       = 1'b0;
    wr_en        = 1'b0;
    rd_clr       = 1'b0;
    rd_en        = 1'b0;
    ra_load      = 1'b0;
    op_done_d    = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_EXPAND: begin
        exp_req     = 1'b1;
        dec_key_gen = bus.exp_valid;
        wr_en       = bus.exp_valid;
        if (bus.exp_valid && wr_at_lim) state_d = ST_READY;
      end
      ST_READY: begin
        key_ready = 1'b1;
        if (bus.op_start) begin
          state_d = ST_CIPHER;
          rd_clr  = 1'b1;
        end
      end
      ST_CIPHER: begin
        key_ready = 1'b1;
        rd_en     = bus.round_adv;
        if (bus.round_adv && rd_at_lim) begin
          state_d   = ST_READY;
          rd_clr    = 1'b1;
          op_done_d = 1'b1;
        end
      end
`ifdef KEY_ZEROIZE_EN
      ST_ZERO: begin
        dec_key_gen  = 1'b1;
        key_zero_sel = 1'b1;
        wr_en        = 1'b1;
        if (wr_at_lim) begin
          state_d = ST_IDLE;
          wr_clr  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (load_ok) begin
      state_d   = ST_EXPAND;
      wr_clr    = 1'b1;
      rd_clr    = 1'b1;
      ra_load   = 1'b1;
      op_done_d = 1'b0;
    end
`ifdef KEY_ZEROIZE_EN
    if (bus.zeroize) begin
      state_d   = ST_ZERO;
      wr_clr    = 1'b1;
      rd_clr    = 1'b1;
      ra_load   = 1'b0;
      op_done_d = 1'b0;
    end
`endif
  end

  assign ra_d = ra_load ? nr_of(key_size_t'(bus.key_size)) : ra_q;

  // State, round amount and completion pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ra_q      <= NR_128;
      op_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ra_q      <= ra_d;
      op_done_q <= op_done_d;
    end
  end

  assign bus.exp_req     = exp_req;
  assign bus.dec_key_gen = dec_key_gen;
  assign bus.writeRound  = wr_cnt;
  assign bus.readRound   = rd_cnt;
  assign bus.roundAmount = ra_q;
  assign bus.key_ready   = key_ready;
  assign bus.busy        = (state_q != ST_READY) && (state_q != ST_IDLE);
  assign bus.op_done     = op_done_q;
  assign bus.dbg_state   = state_q;
`ifdef KEY_ZEROIZE_EN
  assign bus.key_zero_sel = key_zero_sel;
`else
  // Without the wipe feature no ZERO state exists, so this stays low.
  logic unused_zero_sel;
  assign unused_zero_sel = key_zero_sel;
`endif
endmodule
